// File: rtl/p88_image_loader_if.sv
// p88_image_loader_if -- download/write bus of the program-image loader.
//
// Carries the ioctl download handshake (byte stream in, ioctl_wait back)
// and the memory write port (address, data, strobe, target select).
//   master : the image source / memory side (drives ioctl_*, observes mem_*)
//   slave  : the loader (consumes ioctl_*, drives ioctl_wait and mem_*)
interface p88_image_loader_if #(
  parameter int ADDR_W = 18
);
  logic              ioctl_download;
  logic              ioctl_wr;
  logic [7:0]        ioctl_dout;
  logic              ioctl_wait;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_din;
  logic              mem_wr;
  logic              mem_sel;

  modport master (
    output ioctl_download, ioctl_wr, ioctl_dout,
    input  ioctl_wait, mem_addr, mem_din, mem_wr, mem_sel
  );

  modport slave (
    input  ioctl_download, ioctl_wr, ioctl_dout,
    output ioctl_wait, mem_addr, mem_din, mem_wr, mem_sel
  );
endinterface

// File: rtl/p88_image_loader.sv
// p88_image_loader -- parses the ioctl download byte stream.
//
// Records: C8 = section (header + data bytes copied to DRAM),
//          C9 = fill (len copies of one value to DRAM),
//          CA = boot vector (far JMP EA,offL,offH,segL,segH to boot ROM 0..4).
// Ports:
//   clk_sys    : system clock
//   reset      : synchronous, active-high
//   bus        : p88_image_loader_if.slave (ioctl_* in, ioctl_wait/mem_* out)
//   load_reset : system reset request, high while a download is in progress
//   sections   : completed C8/C9 records this download (saturating)
//   boot_set   : a CA record completed this download
//   error      : sticky until the next download starts
// Every byte write holds mem_wr for WR_CYCLES cycles followed by one gap
// cycle; ioctl_wait covers both, so the next byte lands no earlier than
// WR_CYCLES+2 cycles after the previous one.
module p88_image_loader #(
  parameter int ADDR_W    = 18,
  parameter int LEN_W     = 16,
  parameter int WR_CYCLES = 1,
  parameter int BOOT_AW   = 3
) (
  input  logic                 clk_sys,
  input  logic                 reset,
  p88_image_loader_if.slave    bus,
  output logic                 load_reset,
  output logic [7:0]           sections,
  output logic                 boot_set,
  output logic                 error
);

  typedef enum logic [2:0] {
    S_IDLE, S_CMD, S_SEC_HDR, S_SEC_DATA, S_FILL_HDR, S_BOOT_HDR, S_RUN, S_ERR
  } state_t;

  state_t            state_r;
  logic              dl_prev_r;
  logic [2:0]        hdr_idx_r;
  logic [7:0]        lo_r;        // low byte of the 16-bit header field in progress
  logic [15:0]       seg_r;
  logic [15:0]       off_r;
  logic [LEN_W-1:0]  len_r;       // bytes still to write
  logic [ADDR_W-1:0] addr_r;      // next write address (boot index during CA)
  logic [7:0]        fill_val_r;
  logic [2:0]        wr_cnt_r;    // strobe cycles remaining
  logic              gap_r;       // the one idle cycle after each strobe
  logic              wait_r;
  logic              mem_wr_r;
  logic              mem_sel_r;
  logic [ADDR_W-1:0] mem_addr_r;
  logic [7:0]        mem_din_r;
  logic              load_reset_r;
  logic [7:0]        sections_r;
  logic              boot_set_r;
  logic              error_r;

  logic              rise_s;
  logic              fall_s;
  logic              acc_s;
  logic [15:0]       hdr16_s;
  logic [LEN_W-1:0]  len_new_s;
  logic [19:0]       lin20_s;
  logic [ADDR_W-1:0] lin_addr_s;
  logic [7:0]        run_data_s;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  // Far-JMP vector bytes in boot-ROM order.
  function automatic logic [7:0] boot_byte(input logic [2:0] idx,
                                           input logic [15:0] seg,
                                           input logic [15:0] off);
    logic [7:0] b;
    case (idx)
      3'd0:    b = 8'hEA;
      3'd1:    b = off[7:0];
      3'd2:    b = off[15:8];
      3'd3:    b = seg[7:0];
      3'd4:    b = seg[15:8];
      default: b = 8'h00;
    endcase
    return b;
  endfunction

  // Edge detection, byte acceptance and header/address arithmetic.
  always_comb begin
    rise_s     = bus.ioctl_download & ~dl_prev_r;
    fall_s     = ~bus.ioctl_download & dl_prev_r;
    acc_s      = bus.ioctl_wr & ~wait_r;
    hdr16_s    = {bus.ioctl_dout, lo_r};
    len_new_s  = LEN_W'(hdr16_s);
    lin20_s    = {seg_r, 4'h0} + {4'h0, off_r};
    lin_addr_s = ADDR_W'(lin20_s);
    if (mem_sel_r) begin
      run_data_s = boot_byte(addr_r[2:0], seg_r, off_r);
    end else begin
      run_data_s = fill_val_r;
    end
  end

  // Loader state machine, write engine and status registers.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_r      <= S_IDLE;
      dl_prev_r    <= 1'b0;
      hdr_idx_r    <= 3'd0;
      lo_r         <= 8'h00;
      seg_r        <= 16'h0000;
      off_r        <= 16'h0000;
      len_r        <= '0;
      addr_r       <= '0;
      fill_val_r   <= 8'h00;
      wr_cnt_r     <= 3'd0;
      gap_r        <= 1'b0;
      wait_r       <= 1'b0;
      mem_wr_r     <= 1'b0;
      mem_sel_r    <= 1'b0;
      mem_addr_r   <= '0;
      mem_din_r    <= 8'h00;
      load_reset_r <= 1'b0;
      sections_r   <= 8'h00;
      boot_set_r   <= 1'b0;
      error_r      <= 1'b0;
    end else begin
      dl_prev_r <= bus.ioctl_download;
      if (fall_s) begin
        // Download ended: abort any write; mid-record means truncated image.
        load_reset_r <= 1'b0;
        state_r      <= S_IDLE;
        wait_r       <= 1'b0;
        mem_wr_r     <= 1'b0;
        gap_r        <= 1'b0;
        mem_sel_r    <= 1'b0;
        if (state_r != S_CMD && state_r != S_IDLE) begin
          error_r <= 1'b1;
        end
      end else if (rise_s) begin
        load_reset_r <= 1'b1;
        state_r      <= S_CMD;
        sections_r   <= 8'h00;
        boot_set_r   <= 1'b0;
        error_r      <= 1'b0;
        wait_r       <= 1'b0;
        mem_wr_r     <= 1'b0;
        gap_r        <= 1'b0;
        mem_sel_r    <= 1'b0;
        hdr_idx_r    <= 3'd0;
      end else if (mem_wr_r) begin
        // Strobe phase; address/length advance as the strobe ends.
        if (wr_cnt_r == 3'd1) begin
          mem_wr_r <= 1'b0;
          gap_r    <= 1'b1;
          addr_r   <= addr_r + ADDR_W'(1);
          len_r    <= len_r - LEN_W'(1);
        end else begin
          wr_cnt_r <= wr_cnt_r - 3'd1;
        end
      end else if (gap_r) begin
        gap_r <= 1'b0;
        if (state_r == S_RUN && len_r != '0) begin
          // Fill/boot runs chain the next write straight out of the gap.
          mem_wr_r   <= 1'b1;
          wr_cnt_r   <= 3'(WR_CYCLES);
          mem_addr_r <= mem_sel_r ? ADDR_W'(addr_r[BOOT_AW-1:0]) : addr_r;
          mem_din_r  <= run_data_s;
        end else begin
          wait_r <= 1'b0;
          case (state_r)
            S_SEC_DATA: begin
              if (len_r == '0) begin
                sections_r <= sat_inc(sections_r);
                state_r    <= S_CMD;
              end else begin
                state_r <= S_SEC_DATA;
              end
            end
            S_RUN: begin
              if (mem_sel_r) begin
                boot_set_r <= 1'b1;
              end else begin
                sections_r <= sat_inc(sections_r);
              end
              mem_sel_r <= 1'b0;
              state_r   <= S_CMD;
            end
            default: state_r <= state_r;
          endcase
        end
      end else if (acc_s) begin
        case (state_r)
          S_CMD: begin
            hdr_idx_r <= 3'd0;
            case (bus.ioctl_dout)
              8'hC8:   state_r <= S_SEC_HDR;
              8'hC9:   state_r <= S_FILL_HDR;
              8'hCA:   state_r <= S_BOOT_HDR;
              default: begin
                state_r <= S_ERR;
                error_r <= 1'b1;
              end
            endcase
          end
          S_SEC_HDR: begin
            // segL segH offL offH skip skip lenL lenH
            hdr_idx_r <= hdr_idx_r + 3'd1;
            case (hdr_idx_r)
              3'd1:    seg_r <= hdr16_s;
              3'd3:    off_r <= hdr16_s;
              3'd5:    lo_r  <= lo_r;
              3'd7: begin
                len_r  <= len_new_s;
                addr_r <= lin_addr_s;
                if (len_new_s == '0) begin
                  sections_r <= sat_inc(sections_r);
                  state_r    <= S_CMD;
                end else begin
                  state_r <= S_SEC_DATA;
                end
              end
              default: lo_r <= bus.ioctl_dout;
            endcase
          end
          S_SEC_DATA: begin
            mem_wr_r   <= 1'b1;
            wait_r     <= 1'b1;
            wr_cnt_r   <= 3'(WR_CYCLES);
            mem_addr_r <= addr_r;
            mem_din_r  <= bus.ioctl_dout;
            mem_sel_r  <= 1'b0;
          end
          S_FILL_HDR: begin
            // segL segH offL offH lenL lenH value
            hdr_idx_r <= hdr_idx_r + 3'd1;
            case (hdr_idx_r)
              3'd1: seg_r <= hdr16_s;
              3'd3: off_r <= hdr16_s;
              3'd5: len_r <= len_new_s;
              3'd6: begin
                fill_val_r <= bus.ioctl_dout;
                addr_r     <= lin_addr_s;
                if (len_r == '0) begin
                  sections_r <= sat_inc(sections_r);
                  state_r    <= S_CMD;
                end else begin
                  state_r    <= S_RUN;
                  wait_r     <= 1'b1;
                  mem_wr_r   <= 1'b1;
                  wr_cnt_r   <= 3'(WR_CYCLES);
                  mem_addr_r <= lin_addr_s;
                  mem_din_r  <= bus.ioctl_dout;
                  mem_sel_r  <= 1'b0;
                end
              end
              default: lo_r <= bus.ioctl_dout;
            endcase
          end
          S_BOOT_HDR: begin
            // segL segH offL offH, then five vector writes to boot ROM 0..4
            hdr_idx_r <= hdr_idx_r + 3'd1;
            case (hdr_idx_r)
              3'd1: seg_r <= hdr16_s;
              3'd3: begin
                off_r      <= hdr16_s;
                addr_r     <= '0;
                len_r      <= LEN_W'(5);
                state_r    <= S_RUN;
                wait_r     <= 1'b1;
                mem_sel_r  <= 1'b1;
                mem_wr_r   <= 1'b1;
                wr_cnt_r   <= 3'(WR_CYCLES);
                mem_addr_r <= '0;
                mem_din_r  <= 8'hEA;
              end
              default: lo_r <= bus.ioctl_dout;
            endcase
          end
          default: state_r <= state_r;
        endcase
      end else begin
        state_r <= state_r;
      end
    end
  end

  assign bus.ioctl_wait = wait_r;
  assign bus.mem_wr     = mem_wr_r;
  assign bus.mem_sel    = mem_sel_r;
  assign bus.mem_addr   = mem_addr_r;
  assign bus.mem_din    = mem_din_r;
  assign load_reset     = load_reset_r;
  assign sections       = sections_r;
  assign boot_set       = boot_set_r;
  assign error          = error_r;

endmodule

// File: tb/tb_p88_image_loader.sv
// tb_p88_image_loader -- random and directed downloads against a
// record-level reference model of the image format.
module tb_p88_image_loader;
  localparam int AW = 16;
  localparam int WC = 2;

  typedef logic [7:0] byte_q_t[$];
  typedef logic [AW+8:0] wr_t;   // {sel, addr, data}

  logic       clk_sys = 1'b0;
  logic       reset;
  logic       load_reset;
  logic [7:0] sections;
  logic       boot_set;
  logic       error;

  p88_image_loader_if #(.ADDR_W(AW)) bus ();

  p88_image_loader #(.ADDR_W(AW), .LEN_W(16), .WR_CYCLES(WC), .BOOT_AW(3)) dut (
    .clk_sys   (clk_sys),
    .reset     (reset),
    .bus       (bus),
    .load_reset(load_reset),
    .sections  (sections),
    .boot_set  (boot_set),
    .error     (error)
  );

  always #5 clk_sys = ~clk_sys;

  int  vec_cnt = 0;
  int  err_cnt = 0;
  wr_t obs_q[$];
  wr_t exp_q[$];
  bit  mon_en = 1'b0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Write monitor: logs each write and checks strobe shape.
  initial begin
    logic prev_wr;
    int   width;
    wr_t  cur;
    prev_wr = 1'b0;
    width   = 0;
    cur     = '0;
    forever begin
      @(negedge clk_sys);
      if (mon_en) begin
        if (bus.mem_wr) begin
          chk("wait_during_strobe", bus.ioctl_wait, 1);
          if (!prev_wr) begin
            cur = {bus.mem_sel, bus.mem_addr, bus.mem_din};
            obs_q.push_back(cur);
            width = 1;
          end else begin
            chk("strobe_stable", {bus.mem_sel, bus.mem_addr, bus.mem_din}, cur);
            width++;
          end
        end else if (prev_wr) begin
          chk("strobe_width", width, WC);
          chk("gap_wait", bus.ioctl_wait, 1);
        end
      end
      prev_wr = bus.mem_wr;
    end
  end

  // Reference model: walk the byte stream record by record.
  task automatic model(input byte_q_t s, output int secs, output bit boot, output bit err);
    int i, n, seg, off, len, a;
    logic [7:0] bv[5];
    i = 0; n = s.size(); secs = 0; boot = 1'b0; err = 1'b0;
    exp_q.delete();
    while (i < n && !err) begin
      logic [7:0] c;
      c = s[i]; i++;
      if (c == 8'hC8 || c == 8'hC9) begin
        if (n - i < ((c == 8'hC8) ? 8 : 7)) begin
          err = 1'b1;
        end else begin
          seg = {s[i+1], s[i]};
          off = {s[i+3], s[i+2]};
          a   = ((seg * 16 + off) & 32'hFFFFF) % (1 << AW);
          if (c == 8'hC8) begin
            len = {s[i+7], s[i+6]};
            i += 8;
            for (int k = 0; k < len; k++) begin
              if (i >= n) begin err = 1'b1; break; end
              exp_q.push_back({1'b0, AW'(a), s[i]});
              i++;
              a = (a + 1) % (1 << AW);
            end
          end else begin
            len = {s[i+5], s[i+4]};
            for (int k = 0; k < len; k++) begin
              exp_q.push_back({1'b0, AW'(a), s[i+6]});
              a = (a + 1) % (1 << AW);
            end
            i += 7;
          end
          if (!err) secs = (secs < 255) ? secs + 1 : 255;
        end
      end else if (c == 8'hCA) begin
        if (n - i < 4) begin
          err = 1'b1;
        end else begin
          bv[0] = 8'hEA; bv[1] = s[i+2]; bv[2] = s[i+3]; bv[3] = s[i]; bv[4] = s[i+1];
          for (int k = 0; k < 5; k++) exp_q.push_back({1'b1, AW'(k), bv[k]});
          boot = 1'b1;
          i += 4;
        end
      end else begin
        err = 1'b1;
      end
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    int t;
    t = 0;
    @(negedge clk_sys);
    while (bus.ioctl_wait) begin
      // junk offered while busy must be dropped
      if ($urandom_range(0, 3) == 0) begin
        bus.ioctl_wr   = 1'b1;
        bus.ioctl_dout = 8'($urandom);
      end else begin
        bus.ioctl_wr = 1'b0;
      end
      t++;
      if (t > 200) begin
        chk("wait_timeout", t, 0);
        bus.ioctl_wr = 1'b0;
        return;
      end
      @(negedge clk_sys);
    end
    bus.ioctl_wr   = 1'b1;
    bus.ioctl_dout = b;
    @(negedge clk_sys);
    bus.ioctl_wr = 1'b0;
    repeat ($urandom_range(0, 2)) @(negedge clk_sys);
  endtask

  task automatic run_download(input byte_q_t s);
    int t, e_secs;
    bit e_boot, e_err;
    obs_q.delete();
    bus.ioctl_download = 1'b1;
    repeat (2) @(negedge clk_sys);
    chk("load_reset_high", load_reset, 1);
    chk("status_cleared", {sections, boot_set, error}, 0);
    foreach (s[j]) send_byte(s[j]);
    t = 0;
    @(negedge clk_sys);
    while (bus.ioctl_wait && t < 500) begin
      @(negedge clk_sys);
      t++;
    end
    chk("drain_bound", (t < 500), 1);
    repeat (3) @(negedge clk_sys);
    bus.ioctl_download = 1'b0;
    repeat (2) @(negedge clk_sys);
    model(s, e_secs, e_boot, e_err);
    chk("load_reset_low", load_reset, 0);
    chk("write_count", obs_q.size(), exp_q.size());
    for (int k = 0; k < exp_q.size() && k < obs_q.size(); k++) chk("write", obs_q[k], exp_q[k]);
    chk("sections", sections, e_secs);
    chk("boot_set", boot_set, e_boot);
    chk("error", error, e_err);
  endtask

  task automatic gen_stream(output byte_q_t s);
    int nrec, kind, len, cut;
    logic [15:0] seg, off;
    logic [7:0] b;
    s = {};
    nrec = $urandom_range(1, 4);
    for (int r = 0; r < nrec; r++) begin
      kind = $urandom_range(0, 9);
      seg  = 16'($urandom);
      off  = 16'($urandom);
      if ($urandom_range(0, 3) == 0) begin
        seg = 16'hF000;
        off = 16'hFFFC + 16'($urandom_range(0, 3));
      end
      if (kind < 4) begin
        len = $urandom_range(0, 4);
        s.push_back(8'hC8); s.push_back(seg[7:0]); s.push_back(seg[15:8]);
        s.push_back(off[7:0]); s.push_back(off[15:8]);
        s.push_back(8'($urandom)); s.push_back(8'($urandom));
        s.push_back(8'(len)); s.push_back(8'h00);
        for (int k = 0; k < len; k++) s.push_back(8'($urandom));
      end else if (kind < 7) begin
        len = $urandom_range(0, 6);
        s.push_back(8'hC9); s.push_back(seg[7:0]); s.push_back(seg[15:8]);
        s.push_back(off[7:0]); s.push_back(off[15:8]);
        s.push_back(8'(len)); s.push_back(8'h00); s.push_back(8'($urandom));
      end else if (kind < 9) begin
        s.push_back(8'hCA); s.push_back(seg[7:0]); s.push_back(seg[15:8]);
        s.push_back(off[7:0]); s.push_back(off[15:8]);
      end else begin
        b = 8'($urandom);
        if (b >= 8'hC8 && b <= 8'hCA) b = 8'h00;
        s.push_back(b); s.push_back(8'hC8); s.push_back(8'($urandom));
      end
    end
    if ($urandom_range(0, 4) == 0 && s.size() > 1) begin
      cut = $urandom_range(1, s.size() - 1);
      s = s[0:cut-1];
    end
  endtask

  initial begin
    byte_q_t s;
    int hits;
    reset              = 1'b1;
    bus.ioctl_download = 1'b0;
    bus.ioctl_wr       = 1'b0;
    bus.ioctl_dout     = 8'h00;
    repeat (3) @(negedge clk_sys);
    chk("reset_outputs", {load_reset, sections, boot_set, error, bus.ioctl_wait,
                          bus.mem_wr, bus.mem_sel, bus.mem_addr, bus.mem_din}, 0);
    reset = 1'b0;
    repeat (2) @(negedge clk_sys);
    chk("idle_outputs", {load_reset, bus.ioctl_wait, bus.mem_wr}, 0);
    mon_en = 1'b1;

    // Section: 0x10010 truncates to 0x0010 with a 16-bit address
    s = {8'hC8, 8'h00, 8'h10, 8'h10, 8'h00, 8'h11, 8'h22, 8'h03, 8'h00, 8'hAA, 8'hBB, 8'hCC};
    run_download(s);
    chk("sec_first", obs_q[0], {1'b0, 16'h0010, 8'hAA});
    chk("sec_last", obs_q[2], {1'b0, 16'h0012, 8'hCC});
    chk("sec_count", sections, 1);

    // Boot vector
    s = {8'hCA, 8'h34, 8'h12, 8'h78, 8'h56};
    run_download(s);
    chk("boot_first", obs_q[0], {1'b1, 16'h0000, 8'hEA});
    chk("boot_last", obs_q[4], {1'b1, 16'h0004, 8'h12});
    chk("boot_flag", boot_set, 1);

    // Fill wrapping past 0xFFFF
    s = {8'hC9, 8'h00, 8'h00, 8'hFE, 8'hFF, 8'h04, 8'h00, 8'h5A};
    run_download(s);
    chk("fill_wrap", obs_q[2], {1'b0, 16'h0000, 8'h5A});

    // Empty section, then a bad command swallows the rest
    s = {8'hC8, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h7F,
         8'hC8, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01, 8'h00, 8'h99};
    run_download(s);
    chk("bad_cmd_secs", sections, 1);
    chk("bad_cmd_err", error, 1);
    chk("bad_cmd_nowr", obs_q.size(), 0);

    // Download drops after 1 of 3 data bytes
    s = {8'hC8, 8'h00, 8'h20, 8'h00, 8'h00, 8'h00, 8'h00, 8'h03, 8'h00, 8'h44};
    run_download(s);
    chk("trunc_err", error, 1);

    // Reset in the middle of a fill write
    obs_q.delete();
    bus.ioctl_download = 1'b1;
    repeat (2) @(negedge clk_sys);
    s = {8'hC9, 8'h00, 8'h00, 8'h00, 8'h01, 8'h0A, 8'h00, 8'h33};
    foreach (s[j]) send_byte(s[j]);
    hits = 0;
    while (!bus.mem_wr && hits < 50) begin
      @(negedge clk_sys);
      hits++;
    end
    chk("fill_started", bus.mem_wr, 1);
    mon_en = 1'b0;
    reset = 1'b1;
    bus.ioctl_download = 1'b0;
    @(negedge clk_sys);
    chk("reset_mid_fill", {load_reset, sections, boot_set, error, bus.ioctl_wait,
                           bus.mem_wr, bus.mem_sel, bus.mem_addr, bus.mem_din}, 0);
    reset = 1'b0;
    hits = 0;
    repeat (20) begin
      @(negedge clk_sys);
      if (bus.mem_wr) hits++;
    end
    chk("no_wr_after_reset", hits, 0);
    mon_en = 1'b1;

    for (int r = 0; r < 40; r++) begin
      gen_stream(s);
      run_download(s);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/p88_image_loader.md
Name: p88_image_loader

Overview:
- Parametrised successor to the top-level program-image loader; parses the byte stream arriving on the ioctl download port.
- Writes program sections to main DRAM and a far-JMP boot vector to the boot ROM.
- Holds the system in reset for the whole download.
- Adds three things the current loader lacks: a fill record, configurable write-strobe length and address width, and sticky error/status reporting.

Parameters:
- ADDR_W, 18: width of mem_addr; the linear address seg*16+off is truncated to ADDR_W bits (wraps).
- LEN_W, 16: width of the record length fields and the length counter.
- WR_CYCLES, 1: number of cycles mem_wr is held high per byte write (legal range 1..7).
- BOOT_AW, 3: width of the boot-ROM address; vector bytes go to boot addresses 0..4.

Ports:
- clk_sys, in, 1: system clock.
- reset, in, 1: synchronous, active-high.
- ioctl_download, in, 1: high for the duration of an image download.
- ioctl_wr, in, 1: ioctl_dout is valid this cycle.
- ioctl_dout, in, 8: download byte.
- ioctl_wait, out, 1: loader busy; upstream must hold off. A byte is accepted only when ioctl_wr=1 and ioctl_wait=0.
- load_reset, out, 1: system reset request; high while a download is in progress.
- mem_addr, out, ADDR_W: write address.
- mem_din, out, 8: write data.
- mem_wr, out, 1: write strobe.
- mem_sel, out, 1: write target; 0=DRAM, 1=boot ROM (boot ROM uses mem_addr[BOOT_AW-1:0]).
- sections, out, 8: count of completed C8/C9 records in this download; saturates at 255.
- boot_set, out, 1: a CA record completed in this download.
- error, out, 1: sticky until next download start.

Behaviour:
- Reset: all outputs 0; state IDLE; all counters and flags cleared.
- Rising edge of ioctl_download (registered compare with previous value):
  - load_reset<=1, state<=CMD.
  - sections<=0, boot_set<=0, error<=0.
- Falling edge of ioctl_download:
  - load_reset<=0, state<=IDLE, ioctl_wait<=0, mem_wr<=0.
  - If the state was not CMD, error<=1 (truncated record).
  - A write in flight is aborted.
- Bytes received in IDLE are ignored.
- CMD state, on an accepted byte:
  - 0xC8 -> SECTION; 0xC9 -> FILL; 0xCA -> BOOT.
  - Any other byte -> ERR, error<=1. ERR consumes all bytes until the download ends.
- SECTION (C8) header, in order: segL, segH, offL, offH, 2 ignored bytes, lenL, lenH.
  - addr = (seg<<4)+off, computed in 20 bits and then truncated to ADDR_W.
  - If len=0: sections++ and return to CMD.
  - Otherwise each following data byte is written, then addr++ (wrapping modulo 2^ADDR_W) and len--.
  - When len reaches 0: sections++, return to CMD.
- Byte write timing (data accepted in cycle t):
  - mem_addr, mem_din and mem_sel are stable from t+1 through t+WR_CYCLES.
  - mem_wr=1 in cycles t+1..t+WR_CYCLES.
  - ioctl_wait=1 in cycles t+1..t+WR_CYCLES+1.
  - addr and len update in cycle t+WR_CYCLES+1.
  - The next byte can be accepted at t+WR_CYCLES+2 at the earliest.
- FILL (C9) header: segL, segH, offL, offH, lenL, lenH, value.
  - After value is accepted: ioctl_wait=1 continuously; len consecutive writes of value, each WR_CYCLES strobe cycles followed by one gap cycle with mem_wr=0.
  - After the last write: ioctl_wait<=0, sections++, return to CMD.
  - len=0: no writes, sections++.
- BOOT (CA) header: segL, segH, offL, offH.
  - After offH is accepted: ioctl_wait=1; mem_sel=1.
  - Five writes to boot addresses 0..4: 0xEA, offL, offH, segL, segH. Timing per write is the same as FILL.
  - Then ioctl_wait<=0, mem_sel<=0, boot_set<=1, return to CMD.
  - A second CA record overwrites the vector.
- A rising and falling edge can never coincide. If ioctl_wr arrives while ioctl_wait=1, the byte is dropped; upstream is responsible for holding it.
- Reset asserted mid-operation overrides everything in the same cycle.

Test Plan:
- Download C8, seg=0x1000, off=0x0010, skip 2, len=3, data AA BB CC, with WR_CYCLES=1 -> writes to 0x10010/11/12 with mem_sel=0; mem_wr width 1; ioctl_wait for 2 cycles per byte; sections=1; error=0.
- Download CA, seg=0x1234, off=0x5678 -> boot writes EA,78,56,34,12 at ROM addresses 0..4; boot_set=1; ioctl_wait high across all 5 writes.
- Download C9, seg=0, off=0xFFFE, len=4, value=0x5A with ADDR_W=16 -> writes at FFFE, FFFF, 0000, 0001; sections=1.
- Download C8 with len=0 followed by a byte 0x7F -> sections=1; error=1 after the 0x7F; later C8 data is not written.
- Download drops mid-section after 1 of 3 data bytes -> error=1; load_reset falls; state IDLE; a new download clears error.
- Reset asserted during a FILL write -> next cycle all outputs are 0; no further mem_wr.
